// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick helper
// for the four-way mux4 arbiter.
package mux4_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int NREQ = 4;

  // Returns {found, idx}: first set bit of req
  // searching upward from ptr, wrapping 3 -> 0.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    // Walk from the farthest offset down so the
    // nearest set bit is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4.sv
// 4-bit 4:1 data multiplexer.
// Ports: d0..d3 data in, s select, y = d[s].
module mux4 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] s,
  output logic [3:0] y
);

  always_comb begin
    y = d0;
    unique case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requests.
// Ports: req, ptr (highest priority) -> found, idx.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [2:0] w_pick;

  assign w_pick = rr_pick(req, ptr);
  assign found  = w_pick[2];
  assign idx    = w_pick[1:0];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one mux4
// between four requesters on a valid/ready channel.
// Ports: clk, reset_n (sync, low), req/last/d0..d3 in,
//   out_ready in; out_valid/out_data/out_last out,
//   gnt (one-hot), sel (binary), ack (one-hot) out.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] ack
);

  arb_state_t r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;

  logic       w_busy;
  logic       w_acc;
  logic       w_done;
  logic [1:0] w_pptr;
  logic       w_found;
  logic [1:0] w_idx;
  logic [3:0] w_onehot;

  assign w_busy    = (r_state == BUSY);
  assign out_valid = w_busy & req[r_sel];
  assign out_last  = w_busy & last[r_sel];
  assign w_acc     = out_valid & out_ready;
  assign w_done    = w_acc & out_last;
  assign ack       = w_acc ? (4'b0001 << r_sel)
                           : 4'b0000;

  // While busy the only pick that matters is the
  // hand-off after a last beat, which starts just
  // past the current owner.
  assign w_pptr = w_busy ? r_sel + 2'd1 : r_ptr;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (w_pptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_onehot = 4'b0001 << w_idx;

  mux4 u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s  (r_sel),
    .y  (out_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_sel   <= w_idx;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_ptr <= r_sel + 2'd1;
            if (w_found) begin
              r_gnt <= w_onehot;
              r_sel <= w_idx;
            end else begin
              r_gnt   <= 4'b0000;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt = r_gnt;
  assign sel = r_sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized self-checking bench for mux4_rr_arbiter
// against a packet-level round-robin reference model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req, last;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;
  logic       out_valid, out_last;
  logic [3:0] out_data, gnt, ack;
  logic [1:0] sel;

  always #5 clk = ~clk;

  mux4_rr_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .last      (last),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  // Reference model: who owns the channel and
  // where the next search begins.
  bit m_busy = 1'b0;
  int m_own  = 0;
  int m_ptr  = 0;
  int a_idx;
  logic [3:0] g_obs;

  function automatic int pick(input logic [3:0] r,
                              input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic step();
    logic [3:0] dv [4];
    bit         ev, acc;
    int         p;
    #1;
    dv[0] = d0; dv[1] = d1;
    dv[2] = d2; dv[3] = d3;
    ev  = m_busy && req[m_own];
    acc = ev && out_ready;
    g_obs = gnt;
    chk("gnt", gnt,
        m_busy ? 32'(1 << m_own) : 32'd0);
    chk("sel", sel, 32'(m_own));
    chk("valid", out_valid, 32'(ev));
    chk("last", out_last,
        32'(m_busy && last[m_own]));
    chk("data", out_data, 32'(dv[m_own]));
    chk("ack", ack,
        acc ? 32'(1 << m_own) : 32'd0);
    a_idx = acc ? m_own : -1;
    if (!reset_n) begin
      m_busy = 1'b0; m_own = 0; m_ptr = 0;
    end else if (!m_busy) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin m_busy = 1'b1; m_own = p; end
    end else if (acc && last[m_own]) begin
      m_ptr = (m_own + 1) % 4;
      p = pick(req, m_ptr);
      if (p >= 0) m_own = p;
      else m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  int         rem [4];
  logic [3:0] dat [4];
  logic [3:0] fair_exp [6];

  initial begin
    fair_exp = '{4'b0001, 4'b0010, 4'b0100,
                 4'b1000, 4'b0001, 4'b0010};
    reset_n = 1'b0; req = 4'b1111; last = 4'b1111;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fair", g_obs, 32'(fair_exp[i]));
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; req = 4'b1010; last = 4'b1010;
    step();
    step();
    chk("rst_ptr", g_obs, 32'b0010);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      dat[i] = 4'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if (rem[i] == 0 && $urandom_range(0, 3) == 0)
          rem[i] = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        req[i]  = (rem[i] > 0);
        last[i] = (rem[i] == 1);
      end
      d0 = dat[0]; d1 = dat[1];
      d2 = dat[2]; d3 = dat[3];
      out_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
      if (!reset_n) begin
        for (int i = 0; i < 4; i++) rem[i] = 0;
      end else if (a_idx >= 0) begin
        rem[a_idx]--;
        dat[a_idx] = 4'($urandom);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
